taxi_eth_frame_gen: RTL and testbench

TAXI_ETH_FRAME_GEN -- requirements
Module: taxi_eth_frame_gen

---
 rtl/taxi_eth_frame_gen_if.sv | 19 +
 rtl/taxi_eth_frame_gen.sv | 197 +++++++++++++++++++
 tb/tb_taxi_eth_frame_gen.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_eth_frame_gen_if.sv
// AXI-stream style bundle shared by the frame generator output and the completion input.
// src drives a stream, snk consumes one.
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tuser, output tready);
endinterface

// File: rtl/taxi_eth_frame_gen.sv
// Ethernet test-frame generator: dst/src/EtherType header, 32-bit sequence number and an
// incrementing payload, one byte per cycle, with inter-frame gaps and completion counting.
//
// state | meaning
// IDLE  | no run in progress; waiting for start
// HDR   | emitting header bytes 0..13
// PAY   | emitting sequence number and payload bytes
// GAP   | idle cycles between frames, tvalid low
module taxi_eth_frame_gen #(
    parameter int ID_W  = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.src         m_axis_tx,
    taxi_axis_if.snk         s_axis_tx_cpl,
    input  logic [47:0]      cfg_dst_mac,
    input  logic [47:0]      cfg_src_mac,
    input  logic [15:0]      cfg_ethertype,
    input  logic [15:0]      cfg_payload_len,
    input  logic [CNT_W-1:0] cfg_frame_count,
    input  logic [15:0]      cfg_gap,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [CNT_W-1:0] tx_frames,
    output logic [CNT_W-1:0] cpl_frames
);

    typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

    state_t           state_q;
    logic [16:0]      idx_q;
    logic [16:0]      last_idx_q;
    logic [31:0]      seq_q;
    logic [CNT_W-1:0] tx_q;
    logic [CNT_W-1:0] cpl_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      gap_q;
    logic [15:0]      gap_cnt_q;
    logic [47:0]      dst_q;
    logic [47:0]      src_q;
    logic [15:0]      et_q;
    logic             stop_pend_q;
    logic             busy_q;
    logic             tvalid_q;
    logic             tlast_q;
    logic [7:0]       tdata_q;
    logic [7:0]       tid_q;

    logic             xfer;
    logic [16:0]      nxt_idx;
    logic             nxt_last;
    logic [7:0]       nxt_byte;
    logic [143:0]     hdr_vec;
    logic [31:0]      seq_inc;
    logic             run_done;
    logic [15:0]      eff_len;

    always_comb begin
        xfer     = tvalid_q && m_axis_tx.tready;
        nxt_idx  = idx_q + 17'd1;
        nxt_last = (nxt_idx == last_idx_q);
        hdr_vec  = {dst_q, src_q, et_q, seq_q};
        nxt_byte = 8'd0;
        if (nxt_idx < 17'd18) begin
            nxt_byte = hdr_vec[8*(17 - int'(nxt_idx[4:0])) +: 8];
        end else begin
            // payload counts up from the low sequence byte, starting right after the seq field
            nxt_byte = seq_q[7:0] + nxt_idx[7:0] - 8'd18;
        end
        seq_inc  = seq_q + 32'd1;
        run_done = stop || stop_pend_q || ((cnt_q != '0) && ((tx_q + 1'b1) == cnt_q));
        eff_len  = (cfg_payload_len < 16'd4) ? 16'd4 : cfg_payload_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_idx_q  <= '0;
            seq_q       <= '0;
            tx_q        <= '0;
            cpl_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            et_q        <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tid_q       <= '0;
        end else begin
            // a start in IDLE clears first, so a coincident completion counts as the first one
            if (state_q == IDLE && start) begin
                cpl_q <= CNT_W'(s_axis_tx_cpl.tvalid);
            end else if (s_axis_tx_cpl.tvalid) begin
                cpl_q <= cpl_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        dst_q       <= cfg_dst_mac;
                        src_q       <= cfg_src_mac;
                        et_q        <= cfg_ethertype;
                        cnt_q       <= cfg_frame_count;
                        gap_q       <= cfg_gap;
                        last_idx_q  <= 17'(eff_len) + 17'd13;
                        tx_q        <= '0;
                        seq_q       <= '0;
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= HDR;
                        idx_q       <= '0;
                        tvalid_q    <= 1'b1;
                        tlast_q     <= 1'b0;
                        tdata_q     <= cfg_dst_mac[47:40];
                        tid_q       <= '0;
                    end
                end
                HDR, PAY: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (xfer) begin
                        if (tlast_q) begin
                            tx_q  <= tx_q + 1'b1;
                            seq_q <= seq_inc;
                            if (run_done) begin
                                state_q     <= IDLE;
                                busy_q      <= 1'b0;
                                tvalid_q    <= 1'b0;
                                tlast_q     <= 1'b0;
                                stop_pend_q <= 1'b0;
                            end else if (gap_q == 16'd0) begin
                                // back-to-back frames: first byte is presented without a bubble
                                state_q  <= HDR;
                                idx_q    <= '0;
                                tlast_q  <= 1'b0;
                                tdata_q  <= dst_q[47:40];
                                tid_q    <= seq_inc[7:0];
                            end else begin
                                state_q   <= GAP;
                                gap_cnt_q <= gap_q - 16'd1;
                                tvalid_q  <= 1'b0;
                                tlast_q   <= 1'b0;
                            end
                        end else begin
                            idx_q   <= nxt_idx;
                            tdata_q <= nxt_byte;
                            tlast_q <= nxt_last;
                            if (nxt_idx == 17'd14) begin
                                state_q <= PAY;
                            end
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (gap_cnt_q == 16'd0) begin
                        state_q  <= HDR;
                        idx_q    <= '0;
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        tdata_q  <= dst_q[47:40];
                        tid_q    <= seq_q[7:0];
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_axis_tx.tvalid    = tvalid_q;
    assign m_axis_tx.tdata     = tdata_q;
    assign m_axis_tx.tlast     = tlast_q;
    assign m_axis_tx.tid       = ID_W'(tid_q);
    assign m_axis_tx.tkeep     = '1;
    assign m_axis_tx.tuser     = '0;
    assign s_axis_tx_cpl.tready = 1'b1;

    assign busy       = busy_q;
    assign tx_frames  = tx_q;
    assign cpl_frames = cpl_q;

endmodule

// File: tb/tb_taxi_eth_frame_gen.sv
// Scoreboard bench for taxi_eth_frame_gen: stimulus queues expected bytes, a negedge
// monitor pops and compares every transfer and checks hold-under-backpressure and gaps.
module tb_taxi_eth_frame_gen;
    localparam int ID_W  = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(8), .KEEP_W(1), .ID_W(ID_W)) tx_if ();
    taxi_axis_if #(.DATA_W(8), .KEEP_W(1), .ID_W(ID_W)) cpl_if ();

    logic [47:0]      cfg_dst_mac, cfg_src_mac;
    logic [15:0]      cfg_ethertype, cfg_payload_len, cfg_gap;
    logic [CNT_W-1:0] cfg_frame_count;
    logic             start, stop, busy;
    logic [CNT_W-1:0] tx_frames, cpl_frames;

    taxi_eth_frame_gen #(.ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_axis_tx       (tx_if),
        .s_axis_tx_cpl   (cpl_if),
        .cfg_dst_mac     (cfg_dst_mac),
        .cfg_src_mac     (cfg_src_mac),
        .cfg_ethertype   (cfg_ethertype),
        .cfg_payload_len (cfg_payload_len),
        .cfg_frame_count (cfg_frame_count),
        .cfg_gap         (cfg_gap),
        .start           (start),
        .stop            (stop),
        .busy            (busy),
        .tx_frames       (tx_frames),
        .cpl_frames      (cpl_frames)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] tid;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int idle_run = 0;
    bit after_last = 0;
    bit gap_chk_en = 0;
    int exp_gap = 0;
    bit bp_en = 0;
    bit stalled = 0;
    logic [7:0] st_data, st_tid;
    logic       st_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input int i, input logic [47:0] dst,
                                              input logic [47:0] src, input logic [15:0] et,
                                              input logic [31:0] seq);
        logic [7:0] b;
        if (i < 6)       b = 8'(dst >> (8 * (5 - i)));
        else if (i < 12) b = 8'(src >> (8 * (11 - i)));
        else if (i < 14) b = 8'(et >> (8 * (13 - i)));
        else if (i < 18) b = 8'(seq >> (8 * (17 - i)));
        else             b = 8'(seq[7:0] + 8'(i - 18));
        return b;
    endfunction

    task automatic push_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] et, input int len, input logic [31:0] seq);
        int n;
        beat_t bt;
        n = 14 + ((len < 4) ? 4 : len);
        for (int i = 0; i < n; i++) begin
            bt.data = model_byte(i, dst, src, et, seq);
            bt.last = (i == n - 1);
            bt.tid  = seq[7:0];
            exp_q.push_back(bt);
        end
    endtask

    // monitor: new tready for the coming edge, then judge what that edge will transfer
    always @(negedge clk) begin
        tx_if.tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (!rst_n) begin
            stalled    = 0;
            after_last = 0;
        end else begin
            if (stalled) begin
                chk("hold_tvalid", 64'(tx_if.tvalid), 64'd1);
                chk("hold_beat", 64'({tx_if.tdata, tx_if.tlast, tx_if.tid}),
                    64'({st_data, st_last, st_tid}));
            end
            if (!busy) after_last = 0;
            if (tx_if.tvalid && tx_if.tready) begin
                if (after_last && gap_chk_en) chk("gap_cycles", 64'(idle_run), 64'(exp_gap));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h with no byte expected (t=%0t)",
                             tx_if.tdata, $time);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("tdata", 64'(tx_if.tdata), 64'(e.data));
                    chk("tlast", 64'(tx_if.tlast), 64'(e.last));
                    chk("tid", 64'(tx_if.tid), 64'(e.tid));
                    chk("tkeep_tuser", 64'({tx_if.tkeep, tx_if.tuser}), 64'b10);
                end
                xfer_cnt++;
                after_last = tx_if.tlast;
                idle_run   = 0;
            end else if (!tx_if.tvalid) begin
                idle_run++;
            end
            stalled = tx_if.tvalid && !tx_if.tready;
            st_data = tx_if.tdata;
            st_last = tx_if.tlast;
            st_tid  = tx_if.tid;
        end
    end

    task automatic set_cfg(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                           input int len, input int cnt, input int gap);
        cfg_dst_mac     = dst;
        cfg_src_mac     = src;
        cfg_ethertype   = et;
        cfg_payload_len = 16'(len);
        cfg_frame_count = CNT_W'(cnt);
        cfg_gap         = 16'(gap);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) @(negedge clk);
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic wait_xfers(input string name, input int target);
        for (int i = 0; i < 2000 && xfer_cnt < target; i++) @(negedge clk);
        chk(name, 64'(xfer_cnt >= target), 64'd1);
    endtask

    localparam logic [47:0] DST = 48'h00_11_22_33_44_55;
    localparam logic [47:0] SRC = 48'hA0_B1_C2_D3_E4_F5;
    localparam logic [15:0] ET  = 16'h88B5;

    initial begin
        int base;
        start = 0;
        stop  = 0;
        tx_if.tready  = 1'b1;
        cpl_if.tvalid = 1'b0;
        cpl_if.tid    = '0;
        cpl_if.tdata  = '0;
        cpl_if.tkeep  = '0;
        cpl_if.tlast  = 1'b0;
        cpl_if.tuser  = '0;
        set_cfg(DST, SRC, ET, 4, 1, 0);
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 64'(tx_if.tvalid), 64'd0);
        chk("rst_tlast_tdata_tid", 64'({tx_if.tlast, tx_if.tdata, tx_if.tid}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_counters", 64'({tx_frames, cpl_frames}), 64'd0);
        chk("cpl_tready", 64'(cpl_if.tready), 64'd1);
        rst_n = 1'b1;
        pulse_stop();
        chk("stop_in_idle", 64'(busy), 64'd0);

        // single minimal frame
        base = xfer_cnt;
        set_cfg(DST, SRC, ET, 4, 1, 0);
        push_frame(DST, SRC, ET, 4, 0);
        do_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_idle("t1_done", 200);
        chk("t1_tx_frames", 64'(tx_frames), 64'd1);
        chk("t1_bytes", 64'(xfer_cnt - base), 64'd18);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // three frames with gaps; cfg change and restart mid-run must be ignored
        base = xfer_cnt;
        set_cfg(DST, SRC, ET, 10, 3, 5);
        for (int s = 0; s < 3; s++) push_frame(DST, SRC, ET, 10, 32'(s));
        gap_chk_en = 1;
        exp_gap    = 5;
        do_start();
        set_cfg(48'hFFFF_FFFF_FFFF, 48'h1, 16'h0800, 50, 9, 1);
        do_start();
        wait_idle("t2_done", 500);
        gap_chk_en = 0;
        chk("t2_tx_frames", 64'(tx_frames), 64'd3);
        chk("t2_bytes", 64'(xfer_cnt - base), 64'd72);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // random backpressure, same byte stream as full-rate
        set_cfg(DST, SRC, ET, 6, 2, 2);
        for (int s = 0; s < 2; s++) push_frame(DST, SRC, ET, 6, 32'(s));
        bp_en = 1;
        do_start();
        wait_idle("t3_done", 1000);
        bp_en = 0;
        chk("t3_tx_frames", 64'(tx_frames), 64'd2);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // continuous run stopped mid-payload
        base = xfer_cnt;
        set_cfg(DST, SRC, ET, 20, 0, 1);
        push_frame(DST, SRC, ET, 20, 0);
        do_start();
        wait_xfers("t4_reach_payload", base + 20);
        pulse_stop();
        wait_idle("t4_done", 200);
        repeat (30) @(negedge clk);
        chk("t4_tx_frames", 64'(tx_frames), 64'd1);
        chk("t4_bytes", 64'(xfer_cnt - base), 64'd34);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // stop during the gap ends the run on the next cycle
        set_cfg(DST, SRC, ET, 4, 0, 20);
        push_frame(DST, SRC, ET, 4, 0);
        do_start();
        for (int i = 0; i < 200 && tx_frames != 1; i++) @(negedge clk);
        chk("t4b_first_frame", 64'(tx_frames), 64'd1);
        pulse_stop();
        chk("t4b_busy_low", 64'(busy), 64'd0);
        chk("t4b_queue_empty", 64'(exp_q.size()), 64'd0);

        // zero payload length, back-to-back, then completions while idle
        base = xfer_cnt;
        set_cfg(DST, SRC, ET, 0, 2, 0);
        for (int s = 0; s < 2; s++) push_frame(DST, SRC, ET, 0, 32'(s));
        gap_chk_en = 1;
        exp_gap    = 0;
        do_start();
        wait_idle("t5_done", 200);
        gap_chk_en = 0;
        chk("t5_bytes", 64'(xfer_cnt - base), 64'd36);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cpl_if.tvalid = 1'b1;
            cpl_if.tid    = 8'(i);
            @(negedge clk);
            cpl_if.tvalid = 1'b0;
        end
        chk("t5_cpl_frames", 64'(cpl_frames), 64'd2);

        // start coincident with a completion, then reset mid-frame
        base = xfer_cnt;
        set_cfg(DST, SRC, ET, 30, 1, 0);
        push_frame(DST, SRC, ET, 30, 0);
        @(negedge clk);
        start = 1'b1;
        cpl_if.tvalid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cpl_if.tvalid = 1'b0;
        chk("t6_cpl_after_start", 64'(cpl_frames), 64'd1);
        wait_xfers("t6_mid_frame", base + 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(tx_if.tvalid), 64'd0);
        chk("t6_rst_counters", 64'({tx_frames, cpl_frames}), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = xfer_cnt;
        repeat (5) @(negedge clk);
        chk("t6_stay_idle", 64'({busy, 31'(xfer_cnt - base)}), 64'd0);
        set_cfg(DST, SRC, ET, 4, 1, 0);
        push_frame(DST, SRC, ET, 4, 0);
        do_start();
        wait_idle("t6_done", 200);
        chk("t6_tx_frames", 64'(tx_frames), 64'd1);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
